// File: rtl/delay_line_ram.sv
// -----------------------------------------------------------------------------
// delay_line_ram
// Simple dual-port RAM used as the sample store of delay_line. One write port
// and one registered read port share the clock. Read-first behaviour: when the
// read and write addresses match in the same cycle, q returns the contents
// held before the write.
//
// Ports
//   clk : clock, rising edge
//   we  : write enable
//   wa  : write address
//   wd  : write data
//   re  : read enable; q holds while low
//   ra  : read address
//   q   : registered read data
// -----------------------------------------------------------------------------
module delay_line_ram #(
  parameter int WIDTH = 50,
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic             re,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: no reset on the array or its read register -- a reset would stop
  // this mapping onto block RAM; the owner hides stale words with a valid flag.
  // NOTE: non-blocking assignments here give read-first for free: q samples
  // mem[ra] before the write to the same word lands at the end of the step.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
    if (re) begin
      q <= mem[ra];
    end
  end

endmodule

// File: rtl/delay_line.sv
// -----------------------------------------------------------------------------
// delay_line
// Multi-channel programmable sample delay. Every cycle with ce high pushes one
// CHANNELS-wide sample; one cycle later data_o carries the sample pushed
// len_o pushes earlier. All channels share one RAM, pointer and fill counter,
// so they never skew. A delay of zero bypasses the RAM with a plain register.
// valid_o marks outputs that come from samples actually written since the
// last reset or length load.
//
// Ports
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset
//   ce      : sample enable, one push per high cycle, never back-pressured
//   di      : input sample, channel k in [k*DATA_WIDTH +: DATA_WIDTH]
//   len_we  : strobe, loads min(len_i, MAX_LEN) as the new delay
//   len_i   : requested delay
//   len_o   : active delay
//   data_o  : delayed sample, same layout as di
//   valid_o : data_o holds a genuine delayed sample
// -----------------------------------------------------------------------------
module delay_line #(
  parameter  int DATA_WIDTH  = 25,
  parameter  int CHANNELS    = 2,
  parameter  int MAX_LEN     = 512,
  parameter  int DEFAULT_LEN = 512,
  localparam int LW          = $clog2(MAX_LEN + 1),
  localparam int RW          = CHANNELS * DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic [RW-1:0] di,
  input  logic          len_we,
  input  logic [LW-1:0] len_i,
  output logic [LW-1:0] len_o,
  output logic [RW-1:0] data_o,
  output logic          valid_o
);

  localparam int PW = $clog2(MAX_LEN);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_addr;
  logic [LW-1:0] fill;
  logic [LW-1:0] len_q;
  logic [LW-1:0] len_clamped;
  logic [LW-1:0] len_eff;
  logic [LW-1:0] fill_eff;
  logic [LW:0]   ptr_ext;
  logic [LW:0]   len_ext;
  logic [LW:0]   rd_diff;
  logic          byp_sel;
  logic [RW-1:0] byp_q;
  logic [RW-1:0] ram_q;
  logic          valid_q;

  // A load in the same cycle as a push applies to that push, and restarts the
  // fill count from zero before it is compared.
  assign len_clamped = (len_i > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len_i;
  assign len_eff     = len_we ? len_clamped : len_q;
  assign fill_eff    = len_we ? '0 : fill;

  // Read address (wr_ptr - L) mod MAX_LEN, one bit wider than LW so the
  // wrapped sum never overflows for non-power-of-two depths. L = MAX_LEN lands
  // on wr_ptr itself, which read-first turns into the oldest stored sample.
  assign ptr_ext = (LW + 1)'(wr_ptr);
  assign len_ext = (LW + 1)'(len_eff);
  assign rd_diff = (ptr_ext >= len_ext) ? (ptr_ext - len_ext)
                                        : (ptr_ext + (LW + 1)'(MAX_LEN) - len_ext);
  assign rd_addr = PW'(rd_diff);

  delay_line_ram #(
    .WIDTH (RW),
    .DEPTH (MAX_LEN),
    .AW    (PW)
  ) ram (
    .clk (clk),
    .we  (ce),
    .wa  (wr_ptr),
    .wd  (di),
    .re  (ce),
    .ra  (rd_addr),
    .q   (ram_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      fill    <= '0;
      len_q   <= LW'(DEFAULT_LEN);
      valid_q <= 1'b0;
      // Selecting the cleared bypass register makes data_o read zero in reset
      // without touching the RAM.
      byp_sel <= 1'b1;
      byp_q   <= '0;
    end else begin
      if (len_we) begin
        len_q <= len_clamped;
      end
      if (ce) begin
        wr_ptr  <= (wr_ptr == PW'(MAX_LEN - 1)) ? '0 : wr_ptr + PW'(1);
        fill    <= (fill_eff == LW'(MAX_LEN)) ? fill_eff : fill_eff + LW'(1);
        valid_q <= (fill_eff >= len_eff);
        byp_sel <= (len_eff == '0);
        byp_q   <= di;
      end else if (len_we) begin
        // Load without a push: restart the fill, leave the output word alone.
        fill    <= '0;
        valid_q <= 1'b0;
      end
    end
  end

  // Both mux inputs and the select are registers updated only on ce, so
  // data_o holds while ce is low and across a lone length load.
  assign data_o  = byp_sel ? byp_q : ram_q;
  assign valid_o = valid_q;
  assign len_o   = len_q;

endmodule

// File: doc/delay_line.md
DELAY_LINE -- requirements
Module: delay_line

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 25, giving the bits per channel sample.
REQ-002 The block SHALL have parameter CHANNELS, default 2, giving the number of parallel channels sharing one delay.
REQ-003 The block SHALL have parameter MAX_LEN, default 512, giving the maximum delay in samples (any integer >= 2, not restricted to powers of two).
REQ-004 The block SHALL have parameter DEFAULT_LEN, default 512, giving the delay loaded at reset (must satisfy 0 <= DEFAULT_LEN <= MAX_LEN).
REQ-005 LW SHALL denote $clog2(MAX_LEN+1).
REQ-006 Port clk: input, 1 bit, clock; all logic SHALL be on the rising edge.
REQ-007 Port rst_n: input, 1 bit, reset, synchronous, active-low.
REQ-008 Port ce: input, 1 bit, sample enable; each high cycle SHALL push one sample.
REQ-009 Port di: input, CHANNELS*DATA_WIDTH bits, input sample, with channel k in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 Port len_we: input, 1 bit, single-cycle strobe to load len_i.
REQ-011 Port len_i: input, LW bits, requested delay.
REQ-012 Port len_o: output, LW bits, active delay.
REQ-013 Port data_o: output, CHANNELS*DATA_WIDTH bits, delayed sample, laid out the same as di.
REQ-014 Port valid_o: output, 1 bit, high when data_o holds a genuine delayed sample and not stale RAM contents.

Function
REQ-015 Let L = len_o and let x_n be the n-th sample pushed; on a ce cycle pushing x_n, data_o SHALL be x_{n-L} on the following cycle (registered, 1-cycle latency).
REQ-016 While ce is low, data_o, valid_o, the write pointer and the fill counter SHALL hold.
REQ-017 The write pointer SHALL increment on each ce and wrap from MAX_LEN-1 to 0.
REQ-018 The read address SHALL be (wr_ptr - L) modulo MAX_LEN, computed without overflow for non-power-of-two MAX_LEN.
REQ-019 The RAM SHALL behave read-first, so that at L = MAX_LEN, where read address equals write address, data_o returns the old contents x_{n-MAX_LEN}.
REQ-020 At L = 0, data_o SHALL be di registered on ce (RAM bypassed), and valid_o SHALL be 1 after every ce.
REQ-021 The fill counter f SHALL count ce events since the last reset or length load, saturating at MAX_LEN.
REQ-022 On each ce, valid_o SHALL be set to (f >= L), evaluated with f before the increment.
REQ-023 When len_we is high, len_o SHALL load min(len_i, MAX_LEN) on the next cycle.
REQ-024 When len_we is high, f SHALL be cleared, valid_o SHALL clear, and data_o SHALL hold.
REQ-025 On a length load, the write pointer SHALL NOT move and RAM contents SHALL be kept.
REQ-026 If len_we and ce are high in the same cycle, the new length SHALL apply to that sample.
REQ-027 In that case f SHALL become 1 and valid_o SHALL become (0 >= new L), i.e. 1 only for new L = 0.
REQ-028 All channels SHALL share one pointer, one counter and one RAM of width CHANNELS*DATA_WIDTH, with no channel skew.
REQ-029 The block SHALL add no back-pressure; ce SHALL be accepted every cycle.

Reset
REQ-030 While rst_n is low at a clock edge, the block SHALL set wr_ptr=0, f=0, data_o=0, valid_o=0 and len_o=DEFAULT_LEN.
REQ-031 Reset SHALL take priority over ce and len_we.
REQ-032 RAM contents SHALL NOT be reset; valid_o gating alone SHALL hide stale data.
REQ-033 When reset is asserted mid-stream, the next valid_o SHALL occur only after L further ce after reset release.

Structure
REQ-034 The block SHALL use no shared package; LW, the pointer width $clog2(MAX_LEN) and the RAM width SHALL be local constants.
REQ-035 The block SHALL instantiate exactly one sub-module, ram: simple dual-port, read-first, width CHANNELS*DATA_WIDTH, depth MAX_LEN, with read and write enables both tied to ce.
REQ-036 Pointer, counter, bypass mux and valid logic SHALL live in delay_line.

Verification
REQ-037 Scenario 1: MAX_LEN=10, L=10, CHANNELS=2, ce continuous, ch0=n, ch1=1000+n -> valid_o rises after the 11th ce, and then data_o = {1000+n-10, n-10} every cycle.
REQ-038 Scenario 2: MAX_LEN=10, L=3, ce toggled 1-0 -> data_o changes only after ce cycles, and output sequence = input sequence delayed 3 ce events; pointer wraps 9->0 without glitch.
REQ-039 Scenario 3: L=0 -> data_o = previous-cycle di and valid_o=1 from the first ce; len_i=15 with MAX_LEN=10 -> len_o=10.
REQ-040 Scenario 4: streaming at L=4, then len_we with len_i=2 together with a ce -> valid_o low for that cycle and the next 1 ce, then data_o = x_{n-2}.
REQ-041 Scenario 5: rst_n low for 1 cycle mid-stream at L=5 -> data_o=0, valid_o=0 and len_o=DEFAULT_LEN next cycle; valid_o returns after DEFAULT_LEN+1 ce.
REQ-042 Scenario 6: MAX_LEN=12 (non-power-of-two), L=12, 40 samples -> no missing or duplicated samples across three pointer wraps.
